// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and widths for the FIFO write arbiter
package fifo_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Beat counter width; holds BURST_MAX up to 15
  localparam int BEAT_W  = 4;

  // Owner index width; covers up to 8 requesters
  localparam int OWNER_W = 3;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker for the next owner
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last_owner,
  output logic [OWNER_W-1:0] pick,
  output logic               found
);

  // Search circularly starting after last_owner; the largest offset is tried first so the nearest requester wins
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (i == ((int'(last_owner) + off) % NUM_REQ))) begin
          pick  = OWNER_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one FIFO write port (optional FIFO_WR_ARB_ALF_THROTTLE_EN)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_alf,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          busy,
  output logic [2:0]                    owner
);

`ifdef FIFO_WR_ARB_ALF_THROTTLE_EN
  localparam bit ALF_THROTTLE = 1'b1;
`else
  localparam bit ALF_THROTTLE = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   last_owner_q, last_owner_d;

  logic [OWNER_W-1:0]   pick_idx;
  logic                 pick_found;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 req_own;
  logic                 accept;
  logic [BEAT_W-1:0]    beat_next;
  logic                 burst_last;
  logic                 alf_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .pick       (pick_idx),
    .found      (pick_found)
  );

  // Owner-qualified request, accept strobe and end-of-burst conditions; nothing is accepted while reset is low
  always_comb begin
    owner_oh   = NUM_REQ'(1) << owner_q;
    req_own    = |(req & owner_oh);
    accept     = reset && (state_q == BURST) && req_own && !fifo_full;
    beat_next  = beat_cnt_q + BEAT_W'(1);
    burst_last = (beat_next == BEAT_W'(BURST_MAX));
    alf_end    = ALF_THROTTLE && fifo_alf;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      owner_q      <= '0;
      last_owner_q <= OWNER_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state logic: a dropped request always ends ownership, full parks the burst in HOLD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) state_d = BURST;
      end
      BURST: begin
        if (!req_own)                      state_d = IDLE;
        else if (fifo_full)                state_d = HOLD;
        else if (burst_last || alf_end)    state_d = IDLE;
      end
      HOLD: begin
        if (!req_own)                      state_d = IDLE;
        else if (!fifo_full)               state_d = BURST;
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner, beat count and rotation pointer updates
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    if ((state_q == IDLE) && pick_found) begin
      owner_d    = pick_idx;
      beat_cnt_d = '0;
    end
    if (accept) beat_cnt_d = beat_next;
    if ((state_q != IDLE) && (state_d == IDLE)) last_owner_d = owner_q;
  end

  // Outputs: zero-latency grant and write, write data always from the owner's slice
  always_comb begin
    gnt        = accept ? owner_oh : '0;
    fifo_write = accept;
    busy       = (state_q != IDLE);
    owner      = owner_q;
    fifo_din   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWNER_W'(i)) fifo_din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule
